// File: rtl/fir_tap_scheduler.sv
// fir_tap_scheduler: time-multiplexed FIR controller driving one shared
// signed MAC over NTAPS taps per sample. It owns the delay line, the
// coefficient register file and the output shift/saturation stage.
// Optional build macro: FIR_ROUND_EN adds half an output LSB before the
// shift (round half toward +inf). Without it the shift truncates toward
// -inf. Latency and interface are the same in both builds.
module fir_tap_scheduler #(
  parameter int NTAPS = 8,
  parameter int DW    = 8,
  parameter int CW    = 8,
  parameter int ACCW  = 20,
  parameter int SHIFT = 7
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic signed [DW-1:0]       in_data,
  output logic                       in_ready,
  input  logic                       coef_we,
  input  logic [$clog2(NTAPS)-1:0]   coef_addr,
  input  logic signed [CW-1:0]       coef_data,
  output logic                       coef_err,
  output logic                       out_valid,
  output logic signed [DW-1:0]       out_data,
  output logic                       busy
);
  localparam int IW = $clog2(NTAPS);
  // Output saturation bounds, held one bit wider than the accumulator so the
  // optional rounding add cannot overflow before the compare.
  localparam logic signed [ACCW:0] YMAX = {{(ACCW-DW+2){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW:0] YMIN = {{(ACCW-DW+2){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                state;
  logic signed [DW-1:0]  x [NTAPS];
  logic signed [CW-1:0]  c [NTAPS];
  logic signed [ACCW-1:0] acc;
  logic [IW-1:0]         idx;

  logic                  accept;
  logic signed [DW+CW-1:0] prod;
  logic signed [ACCW-1:0]  prod_ext;
  logic signed [ACCW:0]    acc_adj;
  logic signed [ACCW:0]    y;
  logic signed [DW-1:0]    y_sat;

  assign in_ready = (state == IDLE) & ~rst;
  assign accept   = in_valid & in_ready;

  // Full-precision tap product, sign-extended into the accumulator width.
  assign prod     = x[idx] * c[idx];
  assign prod_ext = {{(ACCW-DW-CW){prod[DW+CW-1]}}, prod};

`ifdef FIR_ROUND_EN
  localparam logic [ACCW:0] HALF = {{(ACCW+1-SHIFT){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};
  assign acc_adj = {acc[ACCW-1], acc} + HALF;
`else
  assign acc_adj = {acc[ACCW-1], acc};
`endif

  assign y = acc_adj >>> SHIFT;

  // Clamp the scaled accumulator into the signed output range.
  always_comb begin
    y_sat = y[DW-1:0];
    if (y > YMAX)      y_sat = YMAX[DW-1:0];
    else if (y < YMIN) y_sat = YMIN[DW-1:0];
  end

  // Sequencer: IDLE accepts a sample or a coefficient write, MAC walks the
  // taps one per cycle, OUT publishes the saturated result for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      idx       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      coef_err  <= 1'b0;
      busy      <= 1'b0;
      for (int k = 0; k < NTAPS; k++) begin
        x[k] <= '0;
        c[k] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      coef_err  <= 1'b0;
      // A write only lands in IDLE when no sample is taken the same cycle.
      if (coef_we) begin
        if (state == IDLE && !accept) c[coef_addr] <= coef_data;
        else                          coef_err     <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            for (int k = NTAPS-1; k > 0; k--) x[k] <= x[k-1];
            x[0]  <= in_data;
            acc   <= '0;
            idx   <= '0;
            state <= MAC;
            busy  <= 1'b1;
          end
        end
        MAC: begin
          acc <= acc + prod_ext;
          idx <= idx + IW'(1);
          if (idx == IW'(NTAPS-1)) state <= OUT;
        end
        OUT: begin
          out_data  <= y_sat;
          out_valid <= 1'b1;
          state     <= IDLE;
          busy      <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fir_tap_scheduler.sv
// Directed bench for fir_tap_scheduler (default parameters).
module tb_fir_tap_scheduler;
  logic              clk = 0;
  logic              rst = 1;
  logic              in_valid = 0;
  logic signed [7:0] in_data = 0;
  logic              in_ready;
  logic              coef_we = 0;
  logic [2:0]        coef_addr = 0;
  logic signed [7:0] coef_data = 0;
  logic              coef_err;
  logic              out_valid;
  logic signed [7:0] out_data;
  logic              busy;

  int checks = 0;
  int errors = 0;

  fir_tap_scheduler dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .coef_err(coef_err), .out_valid(out_valid),
    .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [7:0] din;
    int                exp;
  } vec_t;

  vec_t imp [8];
  vec_t sat [16];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Pulse reset for one cycle; in_ready must be low while rst is high.
  task automatic do_reset();
    rst = 1;
    #1;
    chk("ready_in_reset", int'(in_ready), 0);
    @(posedge clk); #1;
    rst = 0;
    #1;
  endtask

  task automatic wr_coef(input int a, input int d);
    coef_addr = 3'(a); coef_data = 8'(d); coef_we = 1;
    @(posedge clk); #1;
    coef_we = 0;
  endtask

  // Wait (bounded) for in_ready, then present one sample for the accept edge.
  task automatic accept(input logic signed [7:0] d);
    int n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready=%0d, expected 1", in_ready);
    end
    in_valid = 1; in_data = d;
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  // Count edges after the accept edge until out_valid; lat=0 on timeout.
  task automatic wait_out(input int start, output int lat, output int y);
    lat = 0; y = 0;
    for (int i = start + 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = i; y = int'(out_data); break; end
    end
  endtask

  task automatic run_sample(input string name, input logic signed [7:0] d,
                            input int exp);
    int lat, y;
    accept(d);
    wait_out(0, lat, y);
    chk({name, "_lat"}, lat, 9);
    chk(name, y, exp);
  endtask

  initial begin
    int lat, y, acc_cnt, ov_cnt, last_acc, gap_bad;
    // Impulse: c[k]=10k, input 127 then zeros -> y[n] = 1270n >> 7.
    for (int i = 0; i < 8; i++) imp[i].din = (i == 0) ? 8'sd127 : 8'sd0;
`ifdef FIR_ROUND_EN
    imp[0].exp = 0;  imp[1].exp = 10; imp[2].exp = 20; imp[3].exp = 30;
    imp[4].exp = 40; imp[5].exp = 50; imp[6].exp = 60; imp[7].exp = 69;
`else
    imp[0].exp = 0;  imp[1].exp = 9;  imp[2].exp = 19; imp[3].exp = 29;
    imp[4].exp = 39; imp[5].exp = 49; imp[6].exp = 59; imp[7].exp = 69;
`endif
    // Saturation: all c=127; 8x127 then 8x-128. Window sums hand-computed.
    for (int i = 0; i < 8; i++) begin
      sat[i].din = 8'sd127;     sat[i].exp = (i == 0) ? 126 : 127;
      sat[i+8].din = -8'sd128;
    end
    sat[8].exp  = 127;  sat[9].exp  = 127;  sat[10].exp = 127; sat[11].exp = -4;
    sat[12].exp = -128; sat[13].exp = -128; sat[14].exp = -128; sat[15].exp = -128;

    @(posedge clk); #1;
    do_reset();
    chk("rst_ready", int'(in_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_coef_err", int'(coef_err), 0);

    // Single tap.
    wr_coef(0, 127);
    chk("idle_wr_no_err", int'(coef_err), 0);
    run_sample("single_tap", 8'sd100, 99);

    // Impulse response.
    do_reset();
    for (int k = 0; k < 8; k++) wr_coef(k, 10 * k);
    foreach (imp[i]) run_sample($sformatf("impulse_%0d", i), imp[i].din, imp[i].exp);

    // Saturation both rails.
    do_reset();
    for (int k = 0; k < 8; k++) wr_coef(k, 127);
    foreach (sat[i]) run_sample($sformatf("sat_%0d", i), sat[i].din, sat[i].exp);

    // Throughput with in_valid held high from a clean IDLE.
    do_reset();
    @(posedge clk); #1;
    in_valid = 1; in_data = 0;
    acc_cnt = 0; ov_cnt = 0; last_acc = -1; gap_bad = 0;
    for (int s = 0; s < 35; s++) begin
      if (out_valid) ov_cnt++;
      if (in_ready) begin
        if (last_acc >= 0 && s - last_acc != 10) gap_bad++;
        last_acc = s; acc_cnt++;
      end
      @(posedge clk); #1;
    end
    in_valid = 0;
    chk("tput_accepts", acc_cnt, 4);
    chk("tput_gap_errs", gap_bad, 0);
    chk("tput_out_pulses", ov_cnt, 3);

    // Busy write rejection.
    do_reset();
    wr_coef(0, 127);
    accept(8'sd100);
    chk("busy_in_mac", int'(busy), 1);
    coef_addr = 0; coef_data = 8'sd5; coef_we = 1;
    @(posedge clk); #1;
    coef_we = 0;
    chk("busy_wr_err", int'(coef_err), 1);
    @(posedge clk); #1;
    chk("busy_wr_err_pulse", int'(coef_err), 0);
    wait_out(2, lat, y);
    chk("busy_wr_lat", lat, 9);
    chk("busy_wr_out", y, 99);
    run_sample("c0_unchanged", 8'sd100, 99);
    // Write colliding with an accept is dropped as well.
    coef_addr = 0; coef_data = 8'sd5; coef_we = 1;
    accept(8'sd100);
    coef_we = 0;
    chk("accept_wr_err", int'(coef_err), 1);
    wait_out(0, lat, y);
    chk("accept_wr_out", y, 99);
    wr_coef(0, 5);
    #1;
    chk("idle_wr_ok", int'(coef_err), 0);
`ifdef FIR_ROUND_EN
    run_sample("new_c0", 8'sd100, 4);
`else
    run_sample("new_c0", 8'sd100, 3);
`endif

    // Reset mid-MAC.
    wr_coef(0, 127);
    accept(8'sd100);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    do_reset();
    chk("midrst_ready", int'(in_ready), 1);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_out_data", int'(out_data), 0);
    ov_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) ov_cnt++;
      @(posedge clk); #1;
    end
    chk("midrst_no_out", ov_cnt, 0);
    run_sample("midrst_zero_coef", 8'sd50, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fir_tap_scheduler.md
Name: fir_tap_scheduler

Overview:
- Time-multiplexed FIR engine controller: sequences one shared signed multiply-accumulate unit over NTAPS taps per input sample.
- Owns the sample delay line, the coefficient register file and the output scaling/saturation.
- Sits between the pin-level wrapper (sample in on dedicated inputs, coefficient load over bidirectional IOs) and the dedicated outputs; replaces a fully parallel tap array to save area.

Parameters:
- NTAPS, 8, number of taps (power of two, 2..16).
- DW, 8, signed sample width, in and out.
- CW, 8, signed coefficient width (Q1.7).
- ACCW, 20, signed accumulator width; must be >= DW+CW+log2(NTAPS).
- SHIFT, 7, arithmetic right shift applied to the accumulator before saturation.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  input sample offered.
- in_data  in  DW  signed sample.
- in_ready  out  1  block can accept a sample.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  log2(NTAPS)  tap index to write.
- coef_data  in  CW  signed coefficient.
- coef_err  out  1  one-cycle pulse: write rejected because busy.
- out_valid  out  1  one-cycle pulse: out_data is new.
- out_data  out  DW  signed filtered sample, held until next out_valid.
- busy  out  1  high in MAC or OUT state.

Behaviour:
- Reset: state IDLE; delay line x[0..NTAPS-1]=0; coef c[0..NTAPS-1]=0; acc=0; tap index=0; out_data=0; out_valid=0; coef_err=0; busy=0.
- in_ready = (state==IDLE) & ~rst, combinational. It is 0 during the reset cycle and 1 on the first cycle after reset.
- FSM IDLE: on in_valid&in_ready, x shifts (x[k]<=x[k-1], x[0]<=in_data), acc<=0, idx<=0, go MAC. Otherwise stay.
- FSM MAC: one tap per cycle, acc <= acc + x[idx]*c[idx]. The product is a full-precision signed DW+CW result, sign-extended to ACCW. idx increments each cycle. After the cycle with idx==NTAPS-1, go OUT. Exactly NTAPS MAC cycles.
- FSM OUT: y = acc >>> SHIFT (arithmetic). Saturate y to [-2^(DW-1), 2^(DW-1)-1] and register it into out_data. Assert out_valid for this one cycle, then return to IDLE.
- Latency: sample accepted at edge T gives out_valid high in cycle T+NTAPS+1 (9 for defaults).
- Throughput: one sample per NTAPS+2 cycles with in_valid held high.
- busy = (state!=IDLE).
- Coefficient writes: coef_we in IDLE (not in the same cycle as a sample accept) writes c[coef_addr]<=coef_data, visible to the next accepted sample.
- Writes when busy, or coinciding with an accept, are dropped; coef_err pulses high the following cycle.
- Accumulator never wraps for legal parameters; saturation happens only at the output.
- Reset mid-operation: the computation is abandoned with no out_valid. Delay line, coefficients and out_data return to reset values.
- in_valid while not ready: the sample is not consumed; the source holds it.

Optional Feature:
- FIR_ROUND_EN defined: add 2^(SHIFT-1) to acc before the shift (round half toward +inf), then saturate.
- FIR_ROUND_EN not defined: plain truncating arithmetic shift (toward -inf). Latency and interface are identical in both builds.

Test Plan:
- Single tap: c0=127, others 0; accept in_data=100 -> out_valid exactly 9 cycles after the accept, out_data=99 in both builds (12700>>7; rounded 12764>>7).
- Impulse response: c[k]=10*k for k=0..7; feed 127 then seven zeros -> outputs 0,9,19,29,39,49,59,69 (truncating build).
- Saturation: all c=127; feed eight samples of 127 -> 8th out_data=127. Then eight samples of -128 -> 8th out_data=-128.
- Handshake/throughput: in_valid held high -> in_ready low for 9 cycles after each accept, accepts exactly 10 cycles apart, one out_valid pulse per accept.
- Busy write rejection: coef_we (addr 0, data 5) during MAC -> coef_err pulses once, c0 unchanged, next output unaffected. Same write in IDLE -> accepted, no coef_err.
- Reset mid-MAC: assert rst for 1 cycle at MAC cycle 3 -> no out_valid, out_data=0, in_ready=1 next cycle. The next sample with all-zero coefficients yields out_data=0.
